// File: rtl/mac_rx_pkt_gen_if.sv
// mac_rx_pkt_gen_if: MAC RX client bus between the packet source and the buffer.
// The master drives data and strobes; the slave answers with the read request.
interface mac_rx_pkt_gen_if #(
  parameter int DATA_W = 32,
  parameter int BEN_W  = $clog2(DATA_W / 8)
);
  logic [DATA_W-1:0] rxd;
  logic [BEN_W-1:0]  ben;
  logic              rxda;
  logic              sop;
  logic              eop;
  logic              dv;
  logic              rxrqrd;

  modport master (
    output rxd, ben, rxda, sop, eop, dv,
    input  rxrqrd
  );

  modport slave (
    input  rxd, ben, rxda, sop, eop, dv,
    output rxrqrd
  );
endinterface

// File: rtl/mac_rx_pkt_gen.sv
// mac_rx_pkt_gen: reproducible LFSR packet source for the MAC RX client port.
// Define MAC_GEN_SEQ_HDR_EN to carry a 16-bit sequence number in each first word.
module mac_rx_pkt_gen #(
  parameter int          DATA_W = 32,
  parameter int          BEN_W  = $clog2(DATA_W / 8),
  parameter int          RD_LAT = 4,
  parameter logic [31:0] SEED   = 32'hACE1_2015
) (
  input  logic                   mac_clk_i,
  input  logic                   mac_rst_n_i,
  input  logic                   cfg_start_i,
  input  logic [15:0]            cfg_pkt_bytes_i,
  input  logic [15:0]            cfg_pkt_num_i,
  input  logic [15:0]            cfg_halt_cnt_i,
  input  logic [15:0]            cfg_halt_len_i,
  input  logic [7:0]             cfg_ipg_i,
  mac_rx_pkt_gen_if.master       rx,
  output logic                   busy_o,
  output logic [15:0]            pkt_cnt_o
);

  localparam int          LANES = DATA_W / 32;
  localparam int          BPW   = DATA_W / 8;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AVAIL,
    S_LAT,
    S_STREAM,
    S_HALT,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [31:0]       lfsr_q;
  logic [15:0]       words_q;
  logic [BEN_W-1:0]  last_ben_q;
  logic [15:0]       num_q;
  logic [15:0]       hcnt_q;
  logic [15:0]       hlen_q;
  logic [7:0]        ipg_q;
  logic [15:0]       word_cnt_q;
  logic [15:0]       halt_wc_q;
  logic [15:0]       tmr_q;
  logic [15:0]       seq_q;

  logic [DATA_W-1:0] rxd_q;
  logic [BEN_W-1:0]  ben_q;
  logic              rxda_q;
  logic              sop_q;
  logic              eop_q;
  logic              dv_q;
  logic              busy_q;
  logic [15:0]       pkt_cnt_q;

  logic [DATA_W-1:0] word_d;
  logic [31:0]       lfsr_d;
  logic [31:0]       walk;
  logic [16:0]       words_calc;
  logic [15:0]       bytes_m1;
  logic              first_w;
  logic              last_w;
  logic              halt_now;
  logic              done_now;
  logic              done_nxt;
  logic              emit;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  assign words_calc = ({1'b0, cfg_pkt_bytes_i} + 17'(BPW - 1)) >> BEN_W;
  assign bytes_m1   = cfg_pkt_bytes_i - 16'd1;

  assign first_w  = (word_cnt_q == 16'd0);
  assign last_w   = (word_cnt_q + 16'd1 == words_q);
  assign halt_now = (hcnt_q != 16'd0) && (halt_wc_q == hcnt_q) && !eop_q;
  assign done_now = (num_q != 16'd0) && (pkt_cnt_q == num_q);
  assign done_nxt = (num_q != 16'd0) && (pkt_cnt_q + 16'd1 == num_q);

  // A word leaves on the edge that ends latency, ends a pause,
  // or follows a non-final, non-pausing word.
  assign emit = ((state_q == S_LAT) && (tmr_q == 16'd0)) ||
                ((state_q == S_HALT) && (tmr_q == 16'd0)) ||
                ((state_q == S_STREAM) && !eop_q && !halt_now);

  always_comb begin
    walk   = lfsr_q;
    word_d = '0;
    for (int i = 0; i < LANES; i++) begin
      word_d[32*i +: 32] = walk;
      walk               = lfsr_step(walk);
    end
    lfsr_d = walk;
`ifdef MAC_GEN_SEQ_HDR_EN
    if (first_w) begin
      word_d        = '0;
      word_d[15:0]  = seq_q;
      lfsr_d        = lfsr_q;
    end
`endif
  end

  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      words_q    <= '0;
      last_ben_q <= '0;
      num_q      <= '0;
      hcnt_q     <= '0;
      hlen_q     <= '0;
      ipg_q      <= '0;
      word_cnt_q <= '0;
      halt_wc_q  <= '0;
      tmr_q      <= '0;
      seq_q      <= '0;
      rxd_q      <= '0;
      ben_q      <= '1;
      rxda_q     <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      dv_q  <= 1'b0;

      if (emit) begin
        rxd_q      <= word_d;
        lfsr_q     <= lfsr_d;
        dv_q       <= 1'b1;
        rxda_q     <= 1'b1;
        sop_q      <= first_w;
        eop_q      <= last_w;
        ben_q      <= last_w ? last_ben_q : '1;
        word_cnt_q <= last_w ? 16'd0 : word_cnt_q + 16'd1;
        halt_wc_q  <= first_w ? 16'd1 : halt_wc_q + 16'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (cfg_start_i && (cfg_pkt_bytes_i != 16'd0)) begin
            words_q    <= words_calc[15:0];
            last_ben_q <= bytes_m1[BEN_W-1:0];
            num_q      <= cfg_pkt_num_i;
            hcnt_q     <= cfg_halt_cnt_i;
            hlen_q     <= cfg_halt_len_i;
            ipg_q      <= cfg_ipg_i;
            word_cnt_q <= '0;
            halt_wc_q  <= '0;
            seq_q      <= '0;
            lfsr_q     <= SEED;
            pkt_cnt_q  <= '0;
            rxda_q     <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_AVAIL;
          end
        end
        S_AVAIL: begin
          if (rx.rxrqrd) begin
            tmr_q   <= 16'(RD_LAT - 1);
            state_q <= S_LAT;
          end
        end
        S_LAT: begin
          if (tmr_q == 16'd0) state_q <= S_STREAM;
          else                tmr_q   <= tmr_q - 16'd1;
        end
        S_STREAM: begin
          if (eop_q) begin
            ben_q     <= '1;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
            seq_q     <= seq_q + 16'd1;
            if (ipg_q != 8'd0) begin
              rxda_q  <= 1'b0;
              tmr_q   <= {8'd0, ipg_q} - 16'd1;
              state_q <= S_GAP;
            end else if (done_nxt) begin
              rxda_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_AVAIL;
            end
          end else if (halt_now) begin
            rxda_q    <= 1'b0;
            halt_wc_q <= '0;
            tmr_q     <= (hlen_q == 16'd0) ? 16'd0 : hlen_q - 16'd1;
            state_q   <= S_HALT;
          end
        end
        S_HALT: begin
          if (tmr_q == 16'd0) state_q <= S_STREAM;
          else                tmr_q   <= tmr_q - 16'd1;
        end
        S_GAP: begin
          if (tmr_q != 16'd0) begin
            tmr_q <= tmr_q - 16'd1;
          end else if (done_now) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rxda_q  <= 1'b1;
            state_q <= S_AVAIL;
          end
        end
      endcase
    end
  end

  assign rx.rxd    = rxd_q;
  assign rx.ben    = ben_q;
  assign rx.rxda   = rxda_q;
  assign rx.sop    = sop_q;
  assign rx.eop    = eop_q;
  assign rx.dv     = dv_q;
  assign busy_o    = busy_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_mac_rx_pkt_gen.sv
// tb_mac_rx_pkt_gen: traces the RX client bus of a 32-bit and a 64-bit
// generator and checks it against a packet-level model of the stream.
module tb_mac_rx_pkt_gen;

  localparam logic [31:0] SEED  = 32'hACE1_2015;
  localparam int          LAT32 = 4;
  localparam int          LAT64 = 1;
  localparam int          TMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0;
  logic        start64 = 1'b0;
  logic [15:0] bytes = '0;
  logic [15:0] num = '0;
  logic [15:0] hcnt = '0;
  logic [15:0] hlen = '0;
  logic [7:0]  ipg = '0;
  logic        rq = 1'b0;
  logic        busy32, busy64;
  logic [15:0] pc32, pc64;

  mac_rx_pkt_gen_if #(.DATA_W(32)) if32 ();
  mac_rx_pkt_gen_if #(.DATA_W(64)) if64 ();
  assign if32.rxrqrd = rq;
  assign if64.rxrqrd = rq;

  mac_rx_pkt_gen #(.DATA_W(32), .RD_LAT(LAT32)) dut32 (
    .mac_clk_i(clk), .mac_rst_n_i(rst_n), .cfg_start_i(start32),
    .cfg_pkt_bytes_i(bytes), .cfg_pkt_num_i(num),
    .cfg_halt_cnt_i(hcnt), .cfg_halt_len_i(hlen), .cfg_ipg_i(ipg),
    .rx(if32), .busy_o(busy32), .pkt_cnt_o(pc32)
  );

  mac_rx_pkt_gen #(.DATA_W(64), .RD_LAT(LAT64)) dut64 (
    .mac_clk_i(clk), .mac_rst_n_i(rst_n), .cfg_start_i(start64),
    .cfg_pkt_bytes_i(bytes), .cfg_pkt_num_i(num),
    .cfg_halt_cnt_i(hcnt), .cfg_halt_len_i(hlen), .cfg_ipg_i(ipg),
    .rx(if64), .busy_o(busy64), .pkt_cnt_o(pc64)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;

  logic [63:0] t_rxd [TMAX];
  logic [2:0]  t_ben [TMAX];
  logic        t_sop [TMAX];
  logic        t_eop [TMAX];
  logic        t_dv  [TMAX];
  logic        t_rxda[TMAX];
  logic        t_busy[TMAX];
  logic        t_rq  [TMAX];
  logic [15:0] t_pc  [TMAX];
  int          tn;

  function automatic void chk(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic bit have(input int k);
    if (k < tn && k < TMAX) return 1'b1;
    chk("trace_short", 128'(tn), 128'(k + 1));
    return 1'b0;
  endfunction

  // x^32+x^22+x^2+x+1, right-shifting Galois form
  function automatic logic [31:0] nxt(input logic [31:0] s);
    logic b;
    b = s[0];
    return (s >> 1) ^ {b, 9'd0, b, 19'd0, b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit w64, input int k);
    if (w64) begin
      t_rxd[k] = if64.rxd;           t_ben[k] = if64.ben;
      t_sop[k] = if64.sop;           t_eop[k] = if64.eop;
      t_dv[k]  = if64.dv;            t_rxda[k] = if64.rxda;
      t_busy[k] = busy64;            t_pc[k] = pc64;
    end else begin
      t_rxd[k] = {32'd0, if32.rxd};  t_ben[k] = {1'b0, if32.ben};
      t_sop[k] = if32.sop;           t_eop[k] = if32.eop;
      t_dv[k]  = if32.dv;            t_rxda[k] = if32.rxda;
      t_busy[k] = busy32;            t_pc[k] = pc32;
    end
  endtask

  task automatic analyse(input bit w64, input int b, input int hc,
                         input int hl, input int ig, input int n,
                         input int npk);
    int          lanes, bpw, words, lat, hl_eff, j, ka, k, e;
    logic [2:0]  lben, all1, eben;
    logic [31:0] st;
    logic [63:0] ew;
    logic        esop, eeop;
    bit          ok;
    lanes  = w64 ? 2 : 1;
    bpw    = w64 ? 8 : 4;
    lat    = w64 ? LAT64 : LAT32;
    words  = (b + bpw - 1) / bpw;
    lben   = 3'((b - 1) % bpw);
    all1   = w64 ? 3'b111 : 3'b011;
    hl_eff = (hl == 0) ? 1 : hl;
    st     = SEED;
    e      = 0;
    for (int p = 0; p < npk; p++) begin
      j = (p == 0) ? 0 : e + ig + 1;
      if (!have(j)) return;
      if (p > 0 && ig > 0) begin
        ok = 1'b1;
        for (int i = e + 1; i <= e + ig; i++)
          ok &= !t_rxda[i] && !t_dv[i] && !t_sop[i] && !t_eop[i];
        chk($sformatf("gap_idle p%0d", p), 128'(ok), 128'(1));
      end
      chk($sformatf("avail p%0d", p), 128'(t_rxda[j]), 128'(1));
      ka = -1;
      for (int i = j + 1; i < tn; i++)
        if (t_rq[i]) begin ka = i; break; end
      if (ka < 0) begin
        chk("accept_timeout", 128'(0), 128'(1));
        return;
      end
      k = ka + lat;
      if (!have(k)) return;
      ok = 1'b1;
      for (int i = j; i < k; i++) ok &= !t_dv[i];
      chk($sformatf("no_dv_before_sop p%0d", p), 128'(ok), 128'(1));
      for (int w = 0; w < words; w++) begin
        if (!have(k)) return;
        ew = '0;
`ifdef MAC_GEN_SEQ_HDR_EN
        if (w == 0) ew[15:0] = 16'(p);
        else
`endif
        for (int l = 0; l < lanes; l++) begin
          ew[32*l +: 32] = st;
          st = nxt(st);
        end
        esop = (w == 0);
        eeop = (w == words - 1);
        eben = eeop ? lben : all1;
        chk($sformatf("word p%0d w%0d", p, w),
            128'({t_dv[k], t_sop[k], t_eop[k], t_ben[k], t_rxd[k]}),
            128'({1'b1, esop, eeop, eben, ew}));
        if (w < words - 1 && hc != 0 && (w + 1) % hc == 0) begin
          if (!have(k + hl_eff)) return;
          ok = 1'b1;
          for (int i = 1; i <= hl_eff; i++)
            ok &= !t_dv[k + i] && !t_rxda[k + i];
          chk($sformatf("halt p%0d w%0d", p, w), 128'(ok), 128'(1));
          k += hl_eff;
        end
        k++;
      end
      e = k - 1;
      if (!have(e + 1)) return;
      chk($sformatf("pkt_cnt p%0d", p), 128'(t_pc[e + 1]), 128'(p + 1));
    end
    if (n != 0 && npk == n) begin
      if (!have(e + ig + 1)) return;
      chk("busy_drop", 128'({t_busy[e + ig], t_busy[e + ig + 1]}),
          128'(2'b10));
    end
  endtask

  // Runs one configuration, scrambling config inputs and pulsing start
  // after launch to show that only the latched values matter.
  task automatic run(input bit w64, input int b, input int n, input int hc,
                     input int hl, input int ig, input int dly,
                     input int npk, input int budget);
    int run_len;
    bytes = 16'(b); num = 16'(n); hcnt = 16'(hc);
    hlen = 16'(hl); ipg = 8'(ig);
    run_len = 0;
    tn = 0;
    for (int k = 0; k < budget && k < TMAX; k++) begin
      if (k == 0) begin
        start32 = !w64;
        start64 = w64;
        rq = (dly == 0);
      end else begin
        start32 = !w64 && ($urandom_range(0, 7) == 0);
        start64 = w64 && ($urandom_range(0, 7) == 0);
        bytes = 16'($urandom); num = 16'($urandom);
        hcnt = 16'($urandom); hlen = 16'($urandom); ipg = 8'($urandom);
        rq = (dly == 0) || (run_len >= dly);
      end
      t_rq[k] = rq;
      tick();
      sample(w64, k);
      run_len = t_rxda[k] ? run_len + 1 : 0;
      tn = k + 1;
      if (n != 0 && !t_busy[k]) break;
    end
    start32 = 1'b0;
    start64 = 1'b0;
    rq = 1'b0;
    if (n != 0) chk("run_end_idle", 128'(t_busy[tn - 1]), 128'(0));
    analyse(w64, b, hc, hl, ig, n, npk);
  endtask

  initial begin
    int  cnt;
    bit  seen_eop;
    repeat (3) tick();
    chk("rst32", 128'({if32.rxda, if32.dv, if32.sop, if32.eop, busy32,
                       if32.ben, pc32, if32.rxd}),
        128'({5'b0, 2'b11, 16'd0, 32'd0}));
    chk("rst64", 128'({if64.rxda, if64.dv, if64.sop, if64.eop, busy64,
                       if64.ben, pc64, if64.rxd}),
        128'({5'b0, 3'b111, 16'd0, 64'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run(1'b0, 20, 1, 0, 0, 3, 0, 1, 200);
    run(1'b1, 13, 1, 0, 0, 2, 0, 1, 200);
    run(1'b0, 4, 1, 0, 0, 0, 0, 1, 100);
    run(1'b0, 400, 1, 10, 10, 2, 0, 1, 400);
    run(1'b0, 16, 3, 0, 0, 5, 7, 3, 300);

    bytes = 16'd0; num = 16'd1; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (3) tick();
    chk("zero_bytes_ignored", 128'({busy32, if32.rxda}), 128'(2'b00));

    for (int r = 0; r < 8; r++)
      run(r[0], int'($urandom_range(1, 60)), int'($urandom_range(1, 3)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
          0, 1500);

    run(1'b0, 8, 0, 0, 0, 1, 0, 3, 60);
    chk("continuous_busy", 128'(t_busy[tn - 1]), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    bytes = 16'd80; num = 16'd1; hcnt = '0; hlen = '0; ipg = '0;
    rq = 1'b1; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    cnt = 0;
    seen_eop = 1'b0;
    for (int i = 0; i < 100 && cnt < 6; i++) begin
      tick();
      if (if32.dv) cnt++;
      if (if32.eop) seen_eop = 1'b1;
    end
    chk("word6_reached", 128'(cnt), 128'(6));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 128'({if32.rxda, if32.dv, if32.sop, if32.eop, busy32,
                           if32.ben, pc32, if32.rxd}),
        128'({5'b0, 2'b11, 16'd0, 32'd0}));
    chk("no_eop_before_rst", 128'(seen_eop), 128'(0));
    rq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(1'b0, 80, 1, 0, 0, 1, 0, 1, 200);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
